// File: rtl/carrier_mixer_iq.sv
// carrier_mixer_iq: I/Q carrier mixer with quarter-wave ROM, 3-stage pipeline.
// Optional macro CARRIER_MIXER_NEG_Q_EN negates the quadrature carrier (e^{-jwt}).
module carrier_mixer_iq #(
    parameter int WIDTH      = 16,
    parameter int COEF_WIDTH = 12,
    parameter int PHASE_BITS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic signed [WIDTH-1:0]      in_data,
    input  logic                         phase_clr,
    input  logic        [PHASE_BITS-1:0] phase_offset,
    output logic                         out_valid,
    output logic signed [WIDTH-1:0]      out_i,
    output logic signed [WIDTH-1:0]      out_q
);

    localparam int N    = 1 << PHASE_BITS;
    localparam int Q    = N / 4;
    localparam int RW   = (Q > 0) ? $clog2(Q + 1) : 1;
    localparam int PW   = WIDTH + COEF_WIDTH;
    localparam int CMAX = (1 << (COEF_WIDTH - 1)) - 1;
    localparam logic signed [PW-1:0] RND = PW'(1 << (COEF_WIDTH - 2));

    // Rounded magnitude C*sin(2*pi*k/N) for k in 0..N/4.
    // Sines are tabulated at 64 points per period; N divides 64.
    function automatic int quarter_mag(input int k);
        real s;
        int  j;
        s = 0.0;
        j = k << (6 - PHASE_BITS);
        case (j)
            0:       s = 0.0;
            1:       s = 0.0980171403295606;
            2:       s = 0.1950903220161283;
            3:       s = 0.2902846772544623;
            4:       s = 0.3826834323650898;
            5:       s = 0.4713967368259976;
            6:       s = 0.5555702330196022;
            7:       s = 0.6343932841636455;
            8:       s = 0.7071067811865476;
            9:       s = 0.7730104533627370;
            10:      s = 0.8314696123025452;
            11:      s = 0.8819212643483550;
            12:      s = 0.9238795325112867;
            13:      s = 0.9569403357322088;
            14:      s = 0.9807852804032304;
            15:      s = 0.9951847266721969;
            16:      s = 1.0;
            default: s = 0.0;
        endcase
        return $rtoi(real'(CMAX) * s + 0.5);
    endfunction

    logic        [COEF_WIDTH-1:0] w_rom [Q+1];

    for (genvar k = 0; k <= Q; k++) begin : g_rom
        localparam int MAG = quarter_mag(k);
        assign w_rom[k] = COEF_WIDTH'(MAG);
    end

    logic        [PHASE_BITS-1:0] r_phase;
    logic        [PHASE_BITS-1:0] w_idx;
    logic        [PHASE_BITS-1:0] w_r;
    logic        [PHASE_BITS-1:0] w_rm;
    logic        [1:0]            w_quad;
    logic        [RW-1:0]         w_r_ix;
    logic        [RW-1:0]         w_rm_ix;
    logic        [COEF_WIDTH-1:0] w_mag_r;
    logic        [COEF_WIDTH-1:0] w_mag_m;
    logic signed [COEF_WIDTH-1:0] w_cos;
    logic signed [COEF_WIDTH-1:0] w_sin;
    logic signed [COEF_WIDTH-1:0] w_sin_q;

    logic                         r_s1_valid;
    logic signed [WIDTH-1:0]      r_s1_data;
    logic signed [COEF_WIDTH-1:0] r_s1_cos;
    logic signed [COEF_WIDTH-1:0] r_s1_sin;

    logic                         r_s2_valid;
    logic signed [PW-1:0]         r_s2_pi;
    logic signed [PW-1:0]         r_s2_pq;

    logic signed [PW-1:0]         w_sum_i;
    logic signed [PW-1:0]         w_sum_q;
    logic signed [WIDTH-1:0]      w_res_i;
    logic signed [WIDTH-1:0]      w_res_q;

    logic                         r_out_valid;
    logic signed [WIDTH-1:0]      r_out_i;
    logic signed [WIDTH-1:0]      r_out_q;

    // A preset strobe overrides the counter for the sample in the same cycle.
    assign w_idx   = phase_clr ? phase_offset : r_phase;
    assign w_quad  = w_idx[PHASE_BITS-1 -: 2];
    assign w_r     = w_idx & PHASE_BITS'(Q - 1);
    assign w_rm    = PHASE_BITS'(Q) - w_r;
    assign w_r_ix  = RW'(w_r);
    assign w_rm_ix = RW'(w_rm);
    assign w_mag_r = w_rom[w_r_ix];
    assign w_mag_m = w_rom[w_rm_ix];

    // Rebuild full-wave cos/sin from the quarter table by quadrant.
    always_comb begin
        w_cos = '0;
        w_sin = '0;
        unique case (w_quad)
            2'd0: begin
                w_cos = w_mag_m;
                w_sin = w_mag_r;
            end
            2'd1: begin
                w_cos = -w_mag_r;
                w_sin = w_mag_m;
            end
            2'd2: begin
                w_cos = -w_mag_m;
                w_sin = -w_mag_r;
            end
            default: begin
                w_cos = w_mag_r;
                w_sin = -w_mag_m;
            end
        endcase
    end

`ifdef CARRIER_MIXER_NEG_Q_EN
    assign w_sin_q = -w_sin;
`else
    assign w_sin_q = w_sin;
`endif

    // Phase counter: advances only on accepted samples, preset has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
        end else if (in_valid) begin
            r_phase <= w_idx + 1'b1;
        end else if (phase_clr) begin
            r_phase <= phase_offset;
        end
    end

    // S1: capture the sample and its carrier coefficients.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_cos   <= '0;
            r_s1_sin   <= '0;
        end else begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_data <= in_data;
                r_s1_cos  <= w_cos;
                r_s1_sin  <= w_sin_q;
            end
        end
    end

    // S2: full-precision signed products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_pi    <= '0;
            r_s2_pq    <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_pi <= PW'(r_s1_data) * PW'(r_s1_cos);
                r_s2_pq <= PW'(r_s1_data) * PW'(r_s1_sin);
            end
        end
    end

    // Round half up then drop the coefficient fraction bits.
    assign w_sum_i = r_s2_pi + RND;
    assign w_sum_q = r_s2_pq + RND;
    assign w_res_i = WIDTH'(w_sum_i >>> (COEF_WIDTH - 1));
    assign w_res_q = WIDTH'(w_sum_q >>> (COEF_WIDTH - 1));

    // S3: output registers hold their value between valid samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_i     <= '0;
            r_out_q     <= '0;
        end else begin
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_out_i <= w_res_i;
                r_out_q <= w_res_q;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_i     = r_out_i;
    assign out_q     = r_out_q;

endmodule

// File: tb/tb_carrier_mixer_iq.sv
// tb_carrier_mixer_iq: directed vectors for carrier_mixer_iq (default params).
// Honours CARRIER_MIXER_NEG_Q_EN for the expected quadrature sign.
module tb_carrier_mixer_iq;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic signed [15:0] in_data;
    logic               phase_clr;
    logic        [3:0]  phase_offset;
    logic               out_valid;
    logic signed [15:0] out_i;
    logic signed [15:0] out_q;

    int n_checks = 0;
    int n_errors = 0;

    // C = 2047, N = 16, hand-rounded carrier coefficients
    int cos_c [16] = '{2047, 1891, 1447, 783, 0, -783, -1447, -1891,
                       -2047, -1891, -1447, -783, 0, 783, 1447, 1891};
    int sin_c [16] = '{0, 783, 1447, 1891, 2047, 1891, 1447, 783,
                       0, -783, -1447, -1891, -2047, -1891, -1447, -783};

    // 3-deep expected delay line plus held output values
    bit pv [3];
    int pi [3];
    int pq [3];
    int ei;
    int eq;

    carrier_mixer_iq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .phase_clr    (phase_clr),
        .phase_offset (phase_offset),
        .out_valid    (out_valid),
        .out_i        (out_i),
        .out_q        (out_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 3; i++) begin
            pv[i] = 1'b0;
            pi[i] = 0;
            pq[i] = 0;
        end
        ei = 0;
        eq = 0;
    endtask

    // One clock: apply inputs, then check outputs against the delay line.
    task automatic drive(input string tag, input int v, input int d,
                         input int clr, input int off,
                         input int xi, input int xq);
        int q;
        q = xq;
`ifdef CARRIER_MIXER_NEG_Q_EN
        q = -xq;
`endif
        in_valid     = (v != 0);
        in_data      = 16'(d);
        phase_clr    = (clr != 0);
        phase_offset = 4'(off);
        @(posedge clk);
        #1;
        pv[2] = pv[1];
        pi[2] = pi[1];
        pq[2] = pq[1];
        pv[1] = pv[0];
        pi[1] = pi[0];
        pq[1] = pq[0];
        pv[0] = (v != 0);
        pi[0] = xi;
        pq[0] = q;
        if (pv[2]) begin
            ei = pi[2];
            eq = pq[2];
        end
        check({tag, ".valid"}, int'(out_valid), int'(pv[2]));
        check({tag, ".i"}, int'(out_i), ei);
        check({tag, ".q"}, int'(out_q), eq);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive("idle", 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        phase_clr    = 1'b0;
        phase_offset = '0;
        clear_model();
        #12;
        check("rst.valid", int'(out_valid), 0);
        check("rst.i", int'(out_i), 0);
        check("rst.q", int'(out_q), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // full period plus one, 16384 * coef / 2048 = 8 * coef
        for (int k = 0; k < 17; k++) begin
            drive("stream", 1, 16384, 0, 0,
                  8 * cos_c[k % 16], 8 * sin_c[k % 16]);
        end
        idle(3);

        // full-scale rounding corners
        drive("neg_fs", 1, -32768, 1, 0, -32752, 0);
        drive("pos_fs", 1, 32767, 1, 8, -32751, 0);
        idle(3);

        // preset without a sample, then gapped samples at phases 3 and 4
        drive("clr3", 0, 0, 1, 3, 0, 0);
        drive("gap_a", 1, 16384, 0, 0, 6264, 15128);
        drive("gap_0", 0, 16384, 0, 0, 0, 0);
        drive("gap_1", 0, 16384, 0, 0, 0, 0);
        drive("gap_b", 1, 16384, 0, 0, 0, 16376);
        idle(3);

        // preset with a sample in the same cycle, then the next phases
        drive("clr4", 1, 16384, 1, 4, 0, 16376);
        drive("p5", 1, 16384, 0, 0, -6264, 15128);
        drive("p6", 1, 16384, 0, 0, -11576, 11576);

        // reset with samples in flight
        rst_n = 1'b0;
        #1;
        check("mid_rst.valid", int'(out_valid), 0);
        check("mid_rst.i", int'(out_i), 0);
        check("mid_rst.q", int'(out_q), 0);
        in_valid = 1'b1;
        in_data  = 16'sd16384;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("in_rst.valid", int'(out_valid), 0);
        check("in_rst.i", int'(out_i), 0);
        check("in_rst.q", int'(out_q), 0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        clear_model();
        idle(3);
        drive("post_p0", 1, 16384, 0, 0, 16376, 0);
        drive("post_p1", 1, 16384, 0, 0, 15128, 6264);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/carrier_mixer_iq.md
Name: carrier_mixer_iq

Overview:
Parametrised I/Q carrier mixer for the QAM-16 receiver front end. It multiplies each valid input sample by a cosine and a sine carrier sample, both taken from an internal quarter-wave ROM indexed by a phase counter. It produces in-phase and quadrature products on a 3-stage pipeline with a valid handshake. It sits between the ADC sample interface and the I/Q matched filters. It replaces single-channel sine-only mixing with true signed multiply, rounding, phase preset and a stall-tolerant phase counter.

Parameters:
WIDTH, 16, input/output sample width (signed two's complement), 8..24
COEF_WIDTH, 12, signed carrier coefficient width; full scale C = 2^(COEF_WIDTH-1)-1
PHASE_BITS, 4, log2 of samples per carrier period N (N=16 by default); legal range 2..6

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  in_data valid this cycle
in_data  input  WIDTH  signed input sample
phase_clr  input  1  synchronous phase preset strobe
phase_offset  input  PHASE_BITS  phase index loaded by phase_clr
out_valid  output  1  out_i/out_q valid this cycle
out_i  output  WIDTH  signed in-phase product
out_q  output  WIDTH  signed quadrature product

Behaviour:
- Reset (async, rst_n=0): phase counter = 0, all pipeline valid bits = 0, out_valid = 0, out_i = 0, out_q = 0. Reset mid-stream discards all in-flight samples.
- Coefficients:
  - cos_c[k] = round_half_away(C*cos(2*pi*k/N)); sin_c[k] = round_half_away(C*sin(2*pi*k/N)).
  - Stored as a quarter-wave table of N/4+1 magnitudes. Sign and mirror are derived from the top two phase bits.
  - Values must match the formula bit-exactly.
- Phase counter p (PHASE_BITS wide):
  - The sample accepted with in_valid=1 uses index p, and p advances by 1 modulo N.
  - in_valid=0 does not advance p (gaps are transparent).
- phase_clr=1:
  - With in_valid=0: p <= phase_offset.
  - With in_valid=1 in the same cycle: the sample uses phase_offset, and p <= phase_offset+1 mod N.
  - phase_clr has priority over the normal advance.
- Pipeline, latency 3 cycles from in_valid to out_valid, throughput 1 sample/cycle, no backpressure:
  - S1: register in_data, cos_c[idx] and sin_c[idx].
  - S2: full-precision signed products, WIDTH+COEF_WIDTH bits each.
  - S3: add 2^(COEF_WIDTH-2), then arithmetic shift right by COEF_WIDTH-1, truncated to WIDTH. The result always fits because |coef| <= C < 2^(COEF_WIDTH-1), so no saturation logic is required.
- Output registers load only on cycles where the S3 valid bit is 1 and hold their value otherwise.
- out_valid is exactly in_valid delayed by 3 cycles.
- Phase counter and pipeline are independent: phase_clr does not flush in-flight samples.

Optional Feature:
CARRIER_MIXER_NEG_Q_EN
- Defined: the quadrature path uses -sin_c[k] (coherent-demodulation convention e^{-jwt}), so out_q becomes the negation of the undefined-case value. Rounding is still applied after negation of the coefficient, not of the result.
- Undefined: out_q uses +sin_c[k] as specified above.
- out_i and timing are identical in both builds.

Test Plan:
- Reset, then in_valid=1 with in_data=16384 for 16 cycles (defaults) -> out_valid rises 3 cycles after the first valid. Phase 0: out_i=16376, out_q=0. Phase 2: out_i=out_q=11576. Phase 4: out_i=0, out_q=16376. Phase 8: out_i=-16376, out_q=0. The 17th sample repeats phase 0.
- in_data=-32768 at phase 0 -> out_i=-32752, out_q=0. in_data=32767 at phase 8 -> out_i=-32751 (rounding check).
- in_valid toggling 1,0,0,1 with in_data=16384 starting at p=3 -> second sample uses phase 4 (out_q=16376). out_valid mirrors the input pattern delayed 3 cycles; outputs hold during gaps.
- phase_clr=1, phase_offset=4, in_valid=1, in_data=16384 -> that sample gives out_i=0, out_q=16376. The next sample uses phase 5: out_i=-6264, out_q=15128.
- rst_n asserted while 3 samples are in flight -> out_valid, out_i and out_q are 0 immediately. After release, no stale out_valid appears, and the first new sample uses phase 0.
- Build with CARRIER_MIXER_NEG_Q_EN, in_data=16384 at phase 4 -> out_q=-16376, out_i=0.
